// File: rtl/tis_io_bridge_pkg.sv
// Shared constants for the TIS-100 I/O bridge: value range, node width and
// bit positions inside the host status word.
package tis_io_bridge_pkg;

   localparam int TIS_MAX    = 999;
   localparam int TIS_MIN    = -999;
   localparam int TIS_DATA_W = 11;

   localparam int ST_IN_COUNT_LSB  = 0;
   localparam int ST_OUT_COUNT_LSB = 8;
   localparam int ST_IN_FULL       = 16;
   localparam int ST_OUT_EMPTY     = 17;
   localparam int ST_IN_OVERFLOW   = 18;
   localparam int ST_OUT_UNDERFLOW = 19;

endpackage

// File: rtl/tis_sync_fifo.sv
// Single-clock FIFO with (log2(DEPTH)+1)-bit pointers; a push on full is only
// accepted together with a pop. `fault` flags a dropped push or an empty pop.
module tis_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 11
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       fault
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign fault   = (push && full && !do_pop) || (pop && empty);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/tis_io_bridge.sv
// Host <-> TIS-100 node array bridge: clamped host writes feed an input FIFO,
// node results fill an output FIFO, with sticky overflow/underflow flags.
module tis_io_bridge
   import tis_io_bridge_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = TIS_DATA_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               host_wr_en,
   input  logic signed [31:0] host_wr_data,
   input  logic               host_rd_en,
   output logic [31:0]        host_rd_data,
   output logic [31:0]        host_status,
   input  logic               host_clr_flags,
   output logic               node_in_valid,
   output logic [DATA_W-1:0]  node_in_data,
   input  logic               node_in_ready,
   input  logic               node_out_valid,
   input  logic [DATA_W-1:0]  node_out_data,
   output logic               node_out_ready
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] in_din;
   logic [DATA_W-1:0] out_dout;
   logic              in_full, in_empty, in_fault;
   logic              out_full, out_empty, out_fault;
   logic [CW-1:0]     in_count, out_count;
   logic              in_pop, out_push;
   logic              in_overflow, out_underflow;

   function automatic logic [DATA_W-1:0] clamp_val(input logic signed [31:0] v);
      if (v > TIS_MAX)      return DATA_W'(TIS_MAX);
      else if (v < TIS_MIN) return DATA_W'(TIS_MIN);
      else                  return v[DATA_W-1:0];
   endfunction

   assign in_din         = clamp_val(host_wr_data);
   assign node_in_valid  = !in_empty;
   assign in_pop         = node_in_valid && node_in_ready;
   // full derives purely from registered pointers, so ready never sees a same-cycle host pop
   assign node_out_ready = !out_full;
   assign out_push       = node_out_valid && node_out_ready;

   tis_sync_fifo #(.DEPTH(DEPTH), .W(DATA_W)) u_in_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (host_wr_en),
      .pop   (in_pop),
      .din   (in_din),
      .dout  (node_in_data),
      .full  (in_full),
      .empty (in_empty),
      .count (in_count),
      .fault (in_fault)
   );

   tis_sync_fifo #(.DEPTH(DEPTH), .W(DATA_W)) u_out_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (out_push),
      .pop   (host_rd_en),
      .din   (node_out_data),
      .dout  (out_dout),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count),
      .fault (out_fault)
   );

   // Pops are gated by valid and pushes by ready, so each fault can only be the one that matters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_overflow   <= 1'b0;
         out_underflow <= 1'b0;
      end else begin
         in_overflow   <= in_fault  || (in_overflow   && !host_clr_flags);
         out_underflow <= out_fault || (out_underflow && !host_clr_flags);
      end
   end

   assign host_rd_data = out_empty ? 32'd0 : {{(32-DATA_W){out_dout[DATA_W-1]}}, out_dout};

   always_comb begin
      host_status = '0;
      host_status[ST_IN_COUNT_LSB  +: 8] = 8'(in_count);
      host_status[ST_OUT_COUNT_LSB +: 8] = 8'(out_count);
      host_status[ST_IN_FULL]            = in_full;
      host_status[ST_OUT_EMPTY]          = out_empty;
      host_status[ST_IN_OVERFLOW]        = in_overflow;
      host_status[ST_OUT_UNDERFLOW]      = out_underflow;
   end

endmodule

// File: tb/tb_tis_io_bridge.sv
// Scoreboard bench for tis_io_bridge: expected node/host values are queued
// when driven and checked when the DUT hands them over.
module tb_tis_io_bridge;

   localparam int DEPTH  = 8;
   localparam int DATA_W = 11;

   logic               clk = 1'b0;
   logic               reset;
   logic               host_wr_en;
   logic signed [31:0] host_wr_data;
   logic               host_rd_en;
   logic [31:0]        host_rd_data;
   logic [31:0]        host_status;
   logic               host_clr_flags;
   logic               node_in_valid;
   logic [DATA_W-1:0]  node_in_data;
   logic               node_in_ready;
   logic               node_out_valid;
   logic [DATA_W-1:0]  node_out_data;
   logic               node_out_ready;

   logic [DATA_W-1:0]  in_q[$];
   logic [31:0]        out_q[$];
   logic [DATA_W-1:0]  exp_in;
   logic [31:0]        exp_out;
   int                 n_cmp = 0;
   int                 n_err = 0;
   int                 delivered = 0;

   always #5 clk = ~clk;

   tis_io_bridge #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .host_wr_en     (host_wr_en),
      .host_wr_data   (host_wr_data),
      .host_rd_en     (host_rd_en),
      .host_rd_data   (host_rd_data),
      .host_status    (host_status),
      .host_clr_flags (host_clr_flags),
      .node_in_valid  (node_in_valid),
      .node_in_data   (node_in_data),
      .node_in_ready  (node_in_ready),
      .node_out_valid (node_out_valid),
      .node_out_data  (node_out_data),
      .node_out_ready (node_out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic host_push(input int v, input logic [DATA_W-1:0] e, input bit acc);
      host_wr_en   = 1'b1;
      host_wr_data = v;
      step();
      host_wr_en   = 1'b0;
      if (acc) in_q.push_back(e);
   endtask

   task automatic node_push(input int v);
      logic [31:0] w;
      w              = v;
      node_out_valid = 1'b1;
      node_out_data  = w[DATA_W-1:0];
      step();
      node_out_valid = 1'b0;
      out_q.push_back(w);
   endtask

   task automatic clear_flags();
      host_clr_flags = 1'b1;
      step();
      host_clr_flags = 1'b0;
   endtask

   // Handshake monitor: sample mid-cycle, ahead of the edge that commits the transfer.
   always @(negedge clk) begin
      if (!reset) begin
         chk("in_valid", {31'd0, node_in_valid}, {31'd0, in_q.size() != 0});
         if (node_in_valid && node_in_ready) begin
            if (in_q.size() == 0) chk("in_extra", {31'd0, node_in_valid}, 32'd0);
            else begin
               exp_in = in_q.pop_front();
               chk("in_data", {21'd0, node_in_data}, {21'd0, exp_in});
               delivered++;
            end
         end
         if (host_rd_en) begin
            if (out_q.size() == 0) chk("rd_empty", host_rd_data, 32'd0);
            else begin
               exp_out = out_q.pop_front();
               chk("rd_data", host_rd_data, exp_out);
            end
         end
      end
   end

   int                tab_in [4] = '{5, 1500, -2000, -999};
   logic [DATA_W-1:0] tab_exp[4] = '{11'd5, 11'd999, 11'h419, 11'h419};

   initial begin
      int sent;
      int v;
      logic [31:0] vw;
      reset = 1'b1;
      host_wr_en = 1'b0; host_wr_data = '0; host_rd_en = 1'b0; host_clr_flags = 1'b0;
      node_in_ready = 1'b0; node_out_valid = 1'b0; node_out_data = '0;
      #23 reset = 1'b0;

      @(negedge clk);
      chk("rst_status", host_status, 32'h0002_0000);
      chk("rst_in_valid", {31'd0, node_in_valid}, 32'd0);
      chk("rst_out_ready", {31'd0, node_out_ready}, 32'd1);
      chk("rst_rd_data", host_rd_data, 32'd0);
      step();

      // clamping, drained back to back
      node_in_ready = 1'b1;
      for (int i = 0; i < 4; i++) host_push(tab_in[i], tab_exp[i], 1'b1);
      step(); step();

      // overflow with the node stalled
      node_in_ready = 1'b0;
      for (int i = 1; i <= 9; i++) host_push(i, DATA_W'(i), i <= DEPTH);
      @(negedge clk);
      chk("ovf_in_count", {24'd0, host_status[7:0]}, 32'd8);
      chk("ovf_in_full", {31'd0, host_status[16]}, 32'd1);
      chk("ovf_flag", {31'd0, host_status[18]}, 32'd1);
      step();
      clear_flags();
      @(negedge clk);
      chk("ovf_cleared", {31'd0, host_status[18]}, 32'd0);
      step();

      // push on full together with a node pop
      node_in_ready = 1'b1;
      host_push(100, 11'd100, 1'b1);
      node_in_ready = 1'b0;
      @(negedge clk);
      chk("sim_in_count", {24'd0, host_status[7:0]}, 32'd8);
      chk("sim_no_ovf", {31'd0, host_status[18]}, 32'd0);
      step();
      node_in_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) step();
      node_in_ready = 1'b0;
      @(negedge clk);
      chk("drain_in_count", {24'd0, host_status[7:0]}, 32'd0);
      chk("drain_delivered", delivered, 32'd13);
      step();

      // output path and underflow
      node_push(-7);
      @(negedge clk);
      chk("out_rd_data", host_rd_data, 32'hFFFF_FFF9);
      chk("out_count", {24'd0, host_status[15:8]}, 32'd1);
      step();
      host_rd_en = 1'b1;
      step(); step();
      host_rd_en = 1'b0;
      @(negedge clk);
      chk("udf_empty", {31'd0, host_status[17]}, 32'd1);
      chk("udf_flag", {31'd0, host_status[19]}, 32'd1);
      step();
      clear_flags();
      @(negedge clk);
      chk("udf_cleared", {31'd0, host_status[19]}, 32'd0);
      step();

      // output FIFO full: node push blocked even with a host pop the same cycle
      for (int i = 0; i < DEPTH; i++) node_push(i * 50 - 200);
      @(negedge clk);
      chk("ofull_ready", {31'd0, node_out_ready}, 32'd0);
      chk("ofull_count", {24'd0, host_status[15:8]}, 32'd8);
      step();
      node_out_valid = 1'b1; node_out_data = 11'd321; host_rd_en = 1'b1;
      step();
      node_out_valid = 1'b0;
      for (int i = 1; i < DEPTH; i++) step();
      host_rd_en = 1'b0;
      @(negedge clk);
      chk("ofull_drained", {31'd0, host_status[17]}, 32'd1);
      chk("ofull_rd_zero", host_rd_data, 32'd0);
      chk("ofull_ready_back", {31'd0, node_out_ready}, 32'd1);
      chk("ofull_no_udf", {31'd0, host_status[19]}, 32'd0);
      step();

      // wrap-around stream with random stalls
      delivered = 0;
      sent = 0;
      for (int c = 0; c < 1000 && sent < 40; c++) begin
         node_in_ready = ($urandom_range(0, 9) < 6);
         if (in_q.size() < DEPTH) begin
            v  = (sent * 53) % 1999 - 999;
            vw = v;
            host_push(v, vw[DATA_W-1:0], 1'b1);
            sent++;
         end else step();
      end
      node_in_ready = 1'b1;
      for (int c = 0; c < 50 && in_q.size() != 0; c++) step();
      node_in_ready = 1'b0;
      @(negedge clk);
      chk("wrap_delivered", delivered, 32'd40);
      chk("wrap_status", host_status, 32'h0002_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
